seg7_scan_mux: RTL and testbench

Four-digit multiplexed seven-segment scanner that sits downstream of the hex counter/value generators and drives a common-cathode 4-digit display. It accepts a 16-bit word (four hex nibbles) and four decimal points through a valid/ready handshake, and holds each word in a pending register. It applies the word atomically at a frame boundary, so a frame never mixes digits from two words. Each digit slot starts with an anti-ghosting blank interval. Digits are decoded to segments internally, with optional leading-zero blanking.

---
 rtl/seg7_scan_mux.sv | 76 +++++++
 tb/tb_seg7_scan_mux.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: four-digit multiplexed seven-segment scanner with frame-atomic word updates
module seg7_scan_mux #(
  parameter int SCAN_DIV     = 2500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  logic [15:0] r_sc, r_act, r_pend;
  logic [1:0]  r_d;
  logic [3:0]  r_act_dp, r_pend_dp, r_an;
  logic [6:0]  r_seg;
  logic        r_pend_full, r_dp, r_tick;
  logic        w_slot_end, w_bound, w_accept, w_show, w_lz;
  logic [15:0] w_upper;
  logic [3:0]  w_nib;
  always_comb begin
    w_slot_end = r_sc == 16'(SCAN_DIV - 1);
    w_bound    = w_slot_end && r_d == 2'd3;
    w_accept   = in_valid && !r_pend_full;
    w_show     = r_sc >= 16'(BLANK_CYCLES);
    w_upper    = r_act >> {r_d, 2'b00};
    w_nib      = w_upper[3:0];
    w_lz       = blank_lz && r_d != 2'd0 && w_upper == 16'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sc        <= '0;
      r_d         <= '0;
      r_act       <= '0;
      r_act_dp    <= '0;
      r_pend      <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
      r_an        <= '0;
      r_seg       <= '0;
      r_dp        <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_sc <= w_slot_end ? 16'd0 : r_sc + 16'd1;
      r_d  <= w_slot_end ? r_d + 2'd1 : r_d;
      // a word accepted on the boundary edge waits in pending for the next boundary
      if (w_bound && r_pend_full) begin
        r_act       <= r_pend;
        r_act_dp    <= r_pend_dp;
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend      <= value_in;
        r_pend_dp   <= dp_in;
        r_pend_full <= 1'b1;
      end
      r_an   <= w_show ? 4'b0001 << r_d : 4'b0000;
      r_seg  <= (w_show && !w_lz) ? SEG_LUT[w_nib] : 7'h00;
      r_dp   <= w_show && r_act_dp[r_d];
      r_tick <= w_bound;
    end
  end
  assign in_ready   = !r_pend_full;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_tick;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed scenarios plus randomized run against a cycle-count reference model
module tb_seg7_scan_mux;
  localparam int SD = 8, BC = 2, FR = 4 * SD;
  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, blank_lz = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0] dp_in = '0;
  logic in_ready, dp, frame_tick;
  logic [3:0] an;
  logic [6:0] seg;
  int n_chk = 0, n_pass = 0;
  int t, ph, dg;
  logic bnd;
  logic [15:0] m_act, m_pend;
  logic [3:0] m_adp, m_pdp, c_an, e_an;
  logic m_full, c_dp, e_dp, e_tick;
  logic [6:0] c_seg, e_seg;

  seg7_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .value_in(value_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference: position in the scan derived purely from cycles elapsed since reset release.
  always_comb begin
    ph    = t % SD;
    dg    = (t / SD) % 4;
    bnd   = (t % FR) == FR - 1;
    c_an  = (ph >= BC) ? 4'(1 << dg) : 4'h0;
    c_seg = (ph >= BC && !(blank_lz && dg > 0 && (m_act >> (4 * dg)) == 16'h0))
            ? LUT[m_act[4*dg +: 4]] : 7'h00;
    c_dp  = ph >= BC && m_adp[dg];
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      t <= 0; m_act <= '0; m_adp <= '0; m_full <= 1'b0;
      e_an <= '0; e_seg <= '0; e_dp <= 1'b0; e_tick <= 1'b0;
    end else begin
      t <= t + 1; e_an <= c_an; e_seg <= c_seg; e_dp <= c_dp; e_tick <= bnd;
      if (bnd && m_full) begin
        m_act <= m_pend; m_adp <= m_pdp; m_full <= 1'b0;
      end else if (in_valid && !m_full) begin
        m_pend <= value_in; m_pdp <= dp_in; m_full <= 1'b1;
      end
    end
  end

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FR && !ok; i++) begin
      @(negedge clk);
      ok = frame_tick;
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_an [20] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                                4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h4, 4'h4};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({an, seg, dp, frame_tick, in_ready} !== 14'h0001)
      $display("FAIL reset_state got an=%b seg=%h dp=%b ft=%b rdy=%b want 0/00/0/0/1", an, seg, dp, frame_tick, in_ready);
    else n_pass++;
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k <= 20) begin
        n_chk++;
        if (an !== exp_an[k-1] || seg !== (exp_an[k-1] != 4'h0 ? 7'h3F : 7'h00))
          $display("FAIL scan edge=%0d got an=%b seg=%h want an=%b", k, an, seg, exp_an[k-1]);
        else n_pass++;
      end
      n_chk++;
      if (frame_tick !== (k == 32))
        $display("FAIL frame_tick edge=%0d got %b want %b", k, frame_tick, k == 32);
      else n_pass++;
    end
  endtask

  task automatic test_load;
    logic [6:0] exp_s [4] = '{7'h71, 7'h5B, 7'h77, 7'h06};
    bit ok;
    wait_tick(ok);
    repeat (10) @(negedge clk);
    in_valid = 1'b1; value_in = 16'h1A2F; dp_in = 4'b0100;
    @(negedge clk);
    in_valid = 1'b0; value_in = 16'($urandom); dp_in = 4'($urandom);
    ok = 1'b0;
    for (int i = 0; i < FR; i++) begin
      if (frame_tick) begin ok = 1'b1; break; end
      n_chk++;
      if (in_ready !== 1'b0 || (an != 4'h0 && seg !== 7'h3F))
        $display("FAIL tearing i=%0d got an=%b seg=%h rdy=%b want seg=3F rdy=0", i, an, seg, in_ready);
      else n_pass++;
      @(negedge clk);
    end
    n_chk++;
    if (!ok || in_ready !== 1'b1) $display("FAIL load_boundary got tick=%b rdy=%b want 1/1", ok, in_ready);
    else n_pass++;
    for (int d = 0; d < 4; d++) begin
      repeat (d == 0 ? 5 : 8) @(negedge clk);
      n_chk++;
      if (an !== 4'(1 << d) || seg !== exp_s[d] || dp !== (d == 2))
        $display("FAIL load_digit%0d got an=%b seg=%h dp=%b want seg=%h", d, an, seg, dp, exp_s[d]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    in_valid = 1'b1; value_in = 16'h1111; dp_in = 4'h0;
    @(negedge clk);
    value_in = 16'h2222;
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL bp_full got rdy=%b want 0", in_ready); else n_pass++;
    wait_tick(ok);
    n_chk++;
    if (!ok || in_ready !== 1'b1) $display("FAIL bp_release got tick=%b rdy=%b want 1/1", ok, in_ready);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL bp_second_accept got rdy=%b want 0", in_ready); else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++;
    if (an !== 4'b0001 || seg !== 7'h06) $display("FAIL bp_1111_d0 got an=%b seg=%h want 0001/06", an, seg);
    else n_pass++;
    repeat (24) @(negedge clk);
    n_chk++;
    if (an !== 4'b1000 || seg !== 7'h06) $display("FAIL bp_1111_d3 got an=%b seg=%h want 1000/06", an, seg);
    else n_pass++;
    wait_tick(ok);
    repeat (5) @(negedge clk);
    n_chk++;
    if (!ok || an !== 4'b0001 || seg !== 7'h5B) $display("FAIL bp_2222 got an=%b seg=%h want 0001/5B", an, seg);
    else n_pass++;
  endtask

  task automatic test_simul;
    logic [15:0] w;
    w = 16'($urandom);
    w[3:0] = 4'h9;
    repeat (26) @(negedge clk);
    in_valid = 1'b1; value_in = w; dp_in = 4'h0;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (frame_tick !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL simul_edge got ft=%b rdy=%b want 1/0", frame_tick, in_ready);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++;
    if (an !== 4'b0001 || seg !== 7'h5B) $display("FAIL simul_old got an=%b seg=%h want 0001/5B", an, seg);
    else n_pass++;
    repeat (27) @(negedge clk);
    n_chk++;
    if (frame_tick !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL simul_next_tick got ft=%b rdy=%b want 1/1", frame_tick, in_ready);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++;
    if (an !== 4'b0001 || seg !== 7'h6F) $display("FAIL simul_new got an=%b seg=%h want 0001/6F", an, seg);
    else n_pass++;
  endtask

  task automatic test_lz;
    logic [6:0] e_on [4] = '{7'h3F, 7'h66, 7'h00, 7'h00};
    logic [6:0] e_off [4] = '{7'h3F, 7'h66, 7'h3F, 7'h3F};
    bit ok;
    in_valid = 1'b1; value_in = 16'h0040; dp_in = 4'h0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      blank_lz = (p == 0);
      wait_tick(ok);
      for (int d = 0; d < 4; d++) begin
        repeat (d == 0 ? 5 : 8) @(negedge clk);
        n_chk++;
        if (!ok || an !== 4'(1 << d) || seg !== (p == 0 ? e_on[d] : e_off[d]))
          $display("FAIL lz%0d_digit%0d got an=%b seg=%h want seg=%h", p, d, an, seg, p == 0 ? e_on[d] : e_off[d]);
        else n_pass++;
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    in_valid = 1'b1; value_in = 16'hBEEF; dp_in = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (in_ready !== 1'b0) $display("FAIL rm_pending got rdy=%b want 0", in_ready); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 2 * FR && !ok; i++) begin
      @(negedge clk);
      ok = an === 4'b0100;
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (!ok || an !== 4'h0 || seg !== 7'h00 || dp !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rm_reset got an=%b seg=%h dp=%b rdy=%b want 0/00/0/1", an, seg, dp, in_ready);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < FR + 8; i++) begin
      @(negedge clk);
      n_chk++;
      if (in_ready !== 1'b1 || dp !== 1'b0 || (an != 4'h0 && seg !== 7'h3F))
        $display("FAIL rm_after i=%0d got an=%b seg=%h dp=%b rdy=%b want seg=3F dp=0 rdy=1", i, an, seg, dp, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      n_chk++;
      if ({an, seg, dp, frame_tick, in_ready} !== {e_an, e_seg, e_dp, e_tick, !m_full} || !$onehot0(an))
        $display("FAIL random i=%0d got an=%b seg=%h dp=%b ft=%b rdy=%b want an=%b seg=%h dp=%b ft=%b rdy=%b",
                 i, an, seg, dp, frame_tick, in_ready, e_an, e_seg, e_dp, e_tick, !m_full);
      else n_pass++;
      in_valid = $urandom_range(0, 3) == 0;
      value_in = 16'($urandom) >> $urandom_range(0, 15);
      dp_in    = 4'($urandom);
      blank_lz = ($urandom_range(0, 63) == 0) ? ~blank_lz : blank_lz;
      rst_n    = $urandom_range(0, 299) != 0;
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_backpressure;
    test_simul;
    test_lz;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
